// File: rtl/keypad_event_queue.sv
// keypad_event_queue
//   Scans a 4x4 matrix keypad, debounces whole-matrix frames and queues one
//   keycode per accepted press in a first-word-fall-through FIFO that the
//   calculator FSM drains through a valid/ready handshake.
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat while a single
//   key stays held); without it exactly one event is produced per press.
module keypad_event_queue #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_FIRST   = 32,
    parameter int REPEAT_NEXT    = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       fifo_overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE_SCANS);

    // Configuration sanity; repeat timing is validated even when compiled out
    // so a bad setting surfaces before the feature is switched on.
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be in 1..15");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (REPEAT_FIRST < 1 || REPEAT_NEXT < 1) begin : g_bad_repeat
        $error("REPEAT_FIRST and REPEAT_NEXT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

    // Closure count of one column, saturated at 2 (2 means "two or more").
    function automatic logic [1:0] closures(input logic [3:0] closed);
        logic [2:0] n;
        n = {2'b00, closed[0]} + {2'b00, closed[1]} + {2'b00, closed[2]} + {2'b00, closed[3]};
        return (n > 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Saturating merge of two closure counts.
    function automatic logic [1:0] count_sat(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Row of the lowest closed contact; only meaningful for a single closure.
    function automatic logic [1:0] first_row(input logic [3:0] closed);
        if (closed[0])      return 2'd0;
        else if (closed[1]) return 2'd1;
        else if (closed[2]) return 2'd2;
        else                return 2'd3;
    endfunction

    // Physical keypad legend.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    logic [3:0]       row_meta_p0, row_sync_p1;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic             tick, frame_done;
    logic [3:0]       closed, col_code, acc_code, frame_code;
    logic [1:0]       col_n, acc_n, frame_n;
    logic             is_single, is_none, frame_match;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d, cnt_q, cnt_d, cnt_inc;
    logic             push;
    logic [3:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, pop, do_write;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_target;
    logic             rpt_next_q, rpt_next_d;
    assign rpt_inc    = rpt_cnt_q + RPT_W'(1);
    assign rpt_target = rpt_next_q ? RPT_W'(REPEAT_NEXT) : RPT_W'(REPEAT_FIRST);
`endif

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge Clk) begin
        row_meta_p0 <= row_in;
        row_sync_p1 <= row_meta_p0;
    end

    assign tick       = (div_q == DIV_LAST);
    assign frame_done = tick && (col_q == 2'd3);
    assign col_out    = ~(4'b0001 << col_q);

    // Scan divider and column index
    always_ff @(posedge Clk) begin
        if (reset) begin
            div_q <= '0;
            col_q <= 2'd0;
        end else if (tick) begin
            div_q <= '0;
            col_q <= col_q + 2'd1;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Column 0 starts a fresh frame; later columns merge into the running result.
    assign closed      = ~row_sync_p1;
    assign col_n       = closures(closed);
    assign col_code    = keymap(first_row(closed), col_q);
    assign frame_n     = (col_q == 2'd0) ? col_n : count_sat(acc_n, col_n);
    assign frame_code  = (col_n == 2'd1) ? col_code : acc_code;
    assign is_single   = (frame_n == 2'd1);
    assign is_none     = (frame_n == 2'd0);
    assign frame_match = is_single && (frame_code == cand_q);

    // Frame accumulator, updated on every column sample
    always_ff @(posedge Clk) begin
        if (tick) begin
            acc_n    <= frame_n;
            acc_code <= frame_code;
        end
    end

    // Debounce FSM state register
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        cand_q <= cand_d;
    end

    assign cnt_inc = cnt_q + 4'd1;

    // Debounce FSM next-state and push decision, evaluated once per frame
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_cnt_d  = rpt_cnt_q;
        rpt_next_d = rpt_next_q;
`endif
        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (is_single) begin
                        cand_d = frame_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            push    = 1'b1;
                            state_d = PRESSED;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = CAND;
                        end
                    end
                end
                CAND: begin
                    if (frame_match) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            push    = 1'b1;
                            state_d = PRESSED;
                        end
                    end else if (is_single) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        cnt_d   = 4'd1;
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LAST) state_d = IDLE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
            endcase
`ifdef KEYPAD_AUTOREPEAT_EN
            if (state_q == PRESSED && frame_match) begin
                if (rpt_inc == rpt_target) begin
                    push       = 1'b1;
                    rpt_cnt_d  = '0;
                    rpt_next_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_inc;
                end
            end else begin
                rpt_cnt_d  = '0;
                rpt_next_d = 1'b0;
            end
`endif
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat counter register
    always_ff @(posedge Clk) begin
        if (reset) begin
            rpt_cnt_q  <= '0;
            rpt_next_q <= 1'b0;
        end else begin
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_next_q <= rpt_next_d;
        end
    end
`endif

    assign key_held   = (state_q == PRESSED) || (state_q == RELEASE);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign key_valid  = !fifo_empty;
    assign pop        = key_valid && key_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_write   = push && (!fifo_full || pop);
    assign key_code   = key_valid ? mem[rd_ptr[AW-1:0]] : 4'd0;

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge Clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)      rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && fifo_full && !pop) fifo_overflow <= 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge Clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= cand_d;
    end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Bench for keypad_event_queue: a keypad model drives the rows from the
// pressed-key mask and column drive; a frame-level reference model (queue
// based) predicts every output each cycle, plus literal spot checks.
module tb_keypad_event_queue;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 2;
    localparam int DEPTH    = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    localparam int S_IDLE = 0, S_CAND = 1, S_PRESSED = 2, S_RELEASE = 3;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, key_held, fifo_overflow;
    logic       key_ready = 1'b0;
    logic [15:0] keys = 16'h0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    // reference model state
    logic [3:0] mq[$];
    int         m_n = 0;
    bit         m_ovf = 0;
    int         m_st = S_IDLE;
    int         m_cnt = 0;
    logic [3:0] m_cand = 4'h0;

    int vectors = 0;
    int miscompares = 0;

    keypad_event_queue #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(DEPTH),
        .REPEAT_FIRST(32), .REPEAT_NEXT(8)
    ) dut (
        .Clk(Clk), .reset(reset), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .fifo_overflow(fifo_overflow)
    );

    always #5 Clk = ~Clk;

    // keypad: a row reads low when a pressed key sits on the driven column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    function automatic void model_frame(input logic [15:0] mask, input bit full, input bit popped);
        int n;
        bit single, none, pushed;
        logic [3:0] code;
        n = $countones(mask);
        single = (n == 1);
        none = (n == 0);
        pushed = 0;
        code = 4'h0;
        for (int i = 0; i < 16; i++) if (mask[i]) code = kmap[i];
        case (m_st)
            S_IDLE: if (single) begin
                m_cand = code;
                if (DS == 1) begin pushed = 1; m_st = S_PRESSED; end
                else begin m_cnt = 1; m_st = S_CAND; end
            end
            S_CAND: if (single && code == m_cand) begin
                m_cnt++;
                if (m_cnt == DS) begin pushed = 1; m_st = S_PRESSED; end
            end else if (single) begin
                m_cand = code; m_cnt = 1;
            end else m_st = S_IDLE;
            S_PRESSED: if (none) begin
                m_cnt = 1; m_st = (DS == 1) ? S_IDLE : S_RELEASE;
            end
            default: if (none) begin
                m_cnt++;
                if (m_cnt == DS) m_st = S_IDLE;
            end else m_st = S_PRESSED;
        endcase
        if (pushed) begin
            if (full && !popped) m_ovf = 1;
            else mq.push_back(m_cand);
        end
    endfunction

    task automatic check_outputs();
        logic [3:0] one;
        logic [3:0] exp_col, exp_code;
        bit exp_valid, exp_held;
        one = 4'b0001;
        exp_col = ~(one << ((m_n / SCAN_DIV) % 4));
        exp_valid = (mq.size() > 0);
        exp_code = exp_valid ? mq[0] : 4'h0;
        exp_held = (m_st == S_PRESSED) || (m_st == S_RELEASE);
        vectors++;
        if (col_out !== exp_col) begin
            miscompares++; $display("FAIL col_out t=%0t: got %b expected %b", $time, col_out, exp_col);
        end
        if (key_valid !== exp_valid) begin
            miscompares++; $display("FAIL key_valid t=%0t: got %b expected %b", $time, key_valid, exp_valid);
        end
        if (key_code !== exp_code) begin
            miscompares++; $display("FAIL key_code t=%0t: got %h expected %h", $time, key_code, exp_code);
        end
        if (key_held !== exp_held) begin
            miscompares++; $display("FAIL key_held t=%0t: got %b expected %b", $time, key_held, exp_held);
        end
        if (fifo_overflow !== m_ovf) begin
            miscompares++; $display("FAIL fifo_overflow t=%0t: got %b expected %b", $time, fifo_overflow, m_ovf);
        end
    endtask

    // one clock: advance the model on the edge, compare on the falling edge
    task automatic cycle();
        bit pop, full, fe;
        @(posedge Clk);
        if (reset) begin
            mq.delete();
            m_n = 0; m_ovf = 0; m_st = S_IDLE; m_cnt = 0;
        end else begin
            fe = ((m_n % FRAME) == FRAME - 1);
            full = (mq.size() == DEPTH);
            pop = (mq.size() > 0) && key_ready;
            if (pop) void'(mq.pop_front());
            if (fe) model_frame(keys, full, pop);
            m_n++;
        end
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic frames(input logic [15:0] mask, input int nf);
        keys = mask;
        run_cycles(nf * FRAME);
    endtask

    task automatic align();
        while ((m_n % FRAME) != 0) cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run_cycles(n);
        reset = 1'b0;
    endtask

    task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain();
        key_ready = 1'b1;
        while (key_valid === 1'b1 && vectors < 20000) cycle();
        key_ready = 1'b0;
        lit("drain_empty", {3'b0, key_valid}, 4'h0);
        align();
    endtask

    initial begin
        logic [3:0] col_seq [4];
        logic [3:0] exp_pop [4];
        logic [15:0] seq5 [5];
        logic [15:0] m;
        int idx, idx2, hold, kind;

        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_pop = '{4'h1, 4'h2, 4'h3, 4'hA};
        seq5 = '{kbit(0,0), kbit(0,1), kbit(0,2), kbit(0,3), kbit(1,0)};

        // 1. reset state and column stepping
        do_reset(3);
        lit("reset_col", col_out, 4'b1110);
        lit("reset_valid", {3'b0, key_valid}, 4'h0);
        lit("reset_ovf", {3'b0, fifo_overflow}, 4'h0);
        lit("reset_held", {3'b0, key_held}, 4'h0);
        for (int i = 0; i < 4; i++) begin
            run_cycles(SCAN_DIV);
            lit("col_step", col_out, col_seq[i]);
        end

        // 2. hold '5', one event, latency, held until two NONE frames
        frames(kbit(1,1), 1);
        run_cycles(FRAME - 1);
        lit("k5_not_yet", {3'b0, key_valid}, 4'h0);
        run_cycles(1);
        lit("k5_valid", {3'b0, key_valid}, 4'h1);
        lit("k5_code", key_code, 4'h5);
        frames(kbit(1,1), 2);
        frames(16'h0, 1);
        lit("k5_held_rel1", {3'b0, key_held}, 4'h1);
        frames(16'h0, 1);
        lit("k5_held_rel2", {3'b0, key_held}, 4'h0);
        lit("k5_one_entry_code", key_code, 4'h5);
        key_ready = 1'b1;
        run_cycles(1);
        key_ready = 1'b0;
        lit("k5_single_event", {3'b0, key_valid}, 4'h0);
        align();

        // 3. bounce on '7'
        frames(kbit(2,0), 1);
        frames(16'h0, 1);
        lit("k7_bounce_none", {3'b0, key_valid}, 4'h0);
        frames(kbit(2,0), 3);
        frames(16'h0, 2);
        lit("k7_code", key_code, 4'h7);
        drain();

        // 4. '1' and '2' together
        frames(kbit(0,0) | kbit(0,1), 5);
        lit("multi_held", {3'b0, key_held}, 4'h0);
        lit("multi_valid", {3'b0, key_valid}, 4'h0);
        frames(16'h0, 1);

        // 5. overflow with five presses, then pop in order
        for (int i = 0; i < 5; i++) begin
            frames(seq5[i], 2);
            frames(16'h0, 2);
        end
        lit("ovf_set", {3'b0, fifo_overflow}, 4'h1);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lit("ovf_pop_order", key_code, exp_pop[i]);
            run_cycles(1);
        end
        key_ready = 1'b0;
        lit("ovf_empty", {3'b0, key_valid}, 4'h0);
        align();

        // 6. reset mid-debounce with two queued entries and a held key
        frames(kbit(1,3), 2);
        frames(16'h0, 2);
        frames(kbit(1,2), 2);
        frames(16'h0, 2);
        keys = kbit(2,3);
        run_cycles(FRAME + 6);
        do_reset(2);
        lit("rst_valid", {3'b0, key_valid}, 4'h0);
        lit("rst_held", {3'b0, key_held}, 4'h0);
        lit("rst_ovf", {3'b0, fifo_overflow}, 4'h0);
        frames(kbit(2,3), 2);
        lit("rst_new_valid", {3'b0, key_valid}, 4'h1);
        lit("rst_new_code", key_code, 4'hC);
        frames(16'h0, 2);
        drain();

        // 7. randomized frames with random consumer back-pressure
        do_reset(2);
        for (int f = 0; f < 160; f += hold) begin
            kind = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            idx2 = (idx + $urandom_range(1, 15)) % 16;
            if (kind < 4) m = 16'h0;
            else if (kind < 8) m = 16'(1) << idx;
            else m = (16'(1) << idx) | (16'(1) << idx2);
            hold = $urandom_range(1, 4);
            keys = m;
            for (int c = 0; c < hold * FRAME; c++) begin
                key_ready = ($urandom_range(0, 5) == 0);
                cycle();
            end
        end
        key_ready = 1'b0;
        keys = 16'h0;
        run_cycles(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
